// File: rtl/mips_cpu_branch_delay.sv
// Branch-delay-slot sequencer: captures a taken branch/jump target, counts the
// retired delay-slot instructions, then holds a redirect request until it is acknowledged.
module mips_cpu_branch_delay #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DELAY_SLOTS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  instr_done,
  input  logic                  flush,
  input  logic                  redirect_ack,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_address,
  output logic                  pending,
  output logic [2:0]            slots_left,
  output logic                  slot_violation
);

  typedef enum logic [1:0] {IDLE, ARMED, REDIRECT} state_e;

  localparam logic [2:0] SLOTS_INIT = 3'(DELAY_SLOTS);

  state_e                state_q, state_d;
  logic [2:0]            slots_q, slots_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  viol_q, viol_d;

  logic                  req;
  logic [ADDR_WIDTH-1:0] req_tgt;

  assign req     = branch_taken | jump;
  assign req_tgt = jump ? jump_target : branch_target;

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    addr_d  = addr_q;
    viol_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      slots_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = ARMED;
            slots_d = SLOTS_INIT;
            addr_d  = req_tgt;
            viol_d  = branch_taken & jump;
          end
        end
        ARMED: begin
          // Any request here is a branch sitting in a delay slot: drop it.
          viol_d = req;
          if (instr_done && slots_q != 3'd0) begin
            slots_d = slots_q - 3'd1;
            if (slots_q == 3'd1) state_d = REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ack) begin
            if (req) begin
              state_d = ARMED;
              slots_d = SLOTS_INIT;
              addr_d  = req_tgt;
              viol_d  = branch_taken & jump;
            end else begin
              state_d = IDLE;
            end
          end else begin
            viol_d = req;
          end
        end
        default: begin
          state_d = IDLE;
          slots_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slots_q <= 3'd0;
      addr_q  <= '0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      addr_q  <= addr_d;
      viol_q  <= viol_d;
    end
  end

  assign redirect_valid   = (state_q == REDIRECT);
  assign pending          = (state_q != IDLE);
  assign redirect_address = addr_q;
  assign slots_left       = slots_q;
  assign slot_violation   = viol_q;

endmodule

// File: tb/tb_mips_cpu_branch_delay.sv
// Bench for mips_cpu_branch_delay: one instance with one delay slot, one with three,
// driven by shared stimulus; expected redirect targets are queued and popped on each redirect.
module tb_mips_cpu_branch_delay;
  logic        clk = 1'b0;
  logic        reset, bt, jmp, done, flush, ack;
  logic [31:0] btgt, jtgt;
  logic        rv1, pend1, sv1, rv3, pend3, sv3;
  logic [31:0] ra1, ra3;
  logic [2:0]  sl1, sl3;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp1_q[$];
  logic [31:0] exp3_q[$];
  logic        rv1_prev = 1'b0, rv3_prev = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_branch_delay #(.ADDR_WIDTH(32), .DELAY_SLOTS(1)) u1 (
    .clk(clk), .reset(reset), .branch_taken(bt), .branch_target(btgt), .jump(jmp),
    .jump_target(jtgt), .instr_done(done), .flush(flush), .redirect_ack(ack),
    .redirect_valid(rv1), .redirect_address(ra1), .pending(pend1), .slots_left(sl1),
    .slot_violation(sv1));

  mips_cpu_branch_delay #(.ADDR_WIDTH(32), .DELAY_SLOTS(3)) u3 (
    .clk(clk), .reset(reset), .branch_taken(bt), .branch_target(btgt), .jump(jmp),
    .jump_target(jtgt), .instr_done(done), .flush(flush), .redirect_ack(ack),
    .redirect_valid(rv3), .redirect_address(ra3), .pending(pend3), .slots_left(sl3),
    .slot_violation(sv3));

  // Scoreboard: every new redirect must match the oldest queued target.
  always @(negedge clk) begin
    if (rv1 === 1'b1 && !rv1_prev) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++; $display("FAIL sb1_unexpected: redirect to %h, none expected", ra1);
      end else begin
        logic [31:0] e;
        e = exp1_q.pop_front();
        if (ra1 !== e) begin errors++; $display("FAIL sb1_addr: got %h exp %h", ra1, e); end
      end
    end
    if (rv3 === 1'b1 && !rv3_prev) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++; $display("FAIL sb3_unexpected: redirect to %h, none expected", ra3);
      end else begin
        logic [31:0] e;
        e = exp3_q.pop_front();
        if (ra3 !== e) begin errors++; $display("FAIL sb3_addr: got %h exp %h", ra3, e); end
      end
    end
    rv1_prev <= (rv1 === 1'b1);
    rv3_prev <= (rv3 === 1'b1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bt = 0; jmp = 0; done = 0; flush = 0; ack = 0; btgt = '0; jtgt = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); bt = 1; btgt = 32'hDEAD_0000;
    tick(); reset = 0; idle_inputs();
    checks++;
    if ({rv1, pend1, sl1, sv1, ra1} !== 38'd0) begin
      errors++; $display("FAIL reset_u1: rv=%b pend=%b sl=%0d sv=%b addr=%h, exp all zero", rv1, pend1, sl1, sv1, ra1);
    end
    checks++;
    if ({rv3, pend3, sl3, sv3, ra3} !== 38'd0) begin
      errors++; $display("FAIL reset_u3: rv=%b pend=%b sl=%0d sv=%b addr=%h, exp all zero", rv3, pend3, sl3, sv3, ra3);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bt = 1; btgt = 32'h0000_0040; done = 1;  // done in capture cycle belongs to the branch
    exp1_q.push_back(32'h0000_0040);
    tick(); idle_inputs();
    checks++;
    if (pend1 !== 1 || sl1 !== 3'd1 || rv1 !== 0) begin
      errors++; $display("FAIL basic_armed: pend=%b sl=%0d rv=%b exp 1 1 0", pend1, sl1, rv1);
    end
    done = 1; tick(); done = 0;
    checks++;
    if (rv1 !== 1 || ra1 !== 32'h40 || sl1 !== 3'd0) begin
      errors++; $display("FAIL basic_redirect: rv=%b addr=%h sl=%0d exp 1 00000040 0", rv1, ra1, sl1);
    end
    for (int i = 0; i < 3; i++) begin
      done = (i == 1); tick(); done = 0;
      checks++;
      if (rv1 !== 1 || ra1 !== 32'h40) begin
        errors++; $display("FAIL basic_hold%0d: rv=%b addr=%h exp 1 00000040", i, rv1, ra1);
      end
    end
    ack = 1; tick(); ack = 0;
    checks++;
    if (rv1 !== 0 || pend1 !== 0 || ra1 !== 32'h40) begin
      errors++; $display("FAIL basic_ack: rv=%b pend=%b addr=%h exp 0 0 00000040", rv1, pend1, ra1);
    end
  endtask

  task automatic test_multi_slots();
    logic [6:0] pat;
    int         exp_sl;
    do_reset();
    jmp = 1; jtgt = 32'hBFC0_0010;
    exp3_q.push_back(32'hBFC0_0010);
    exp1_q.push_back(32'hBFC0_0010);  // single-slot instance redirects after the first done
    tick(); idle_inputs();
    exp_sl = 3;
    checks++;
    if (sl3 !== 3'd3 || pend3 !== 1) begin
      errors++; $display("FAIL multi_load: sl=%0d pend=%b exp 3 1", sl3, pend3);
    end
    pat = 7'b1001010;  // bit i = instr_done in cycle i, non-consecutive
    for (int i = 0; i < 7; i++) begin
      done = pat[i]; tick(); done = 0;
      if (pat[i]) exp_sl--;
      checks++;
      if (sl3 !== 3'(exp_sl) || rv3 !== (exp_sl == 0)) begin
        errors++; $display("FAIL multi_cyc%0d: sl=%0d rv=%b exp %0d %b", i, sl3, rv3, exp_sl, exp_sl == 0);
      end
    end
    checks++;
    if (ra3 !== 32'hBFC0_0010) begin
      errors++; $display("FAIL multi_addr: got %h exp bfc00010", ra3);
    end
    ack = 1; tick(); ack = 0;
    checks++;
    if (pend3 !== 0 || rv3 !== 0) begin
      errors++; $display("FAIL multi_ack: pend=%b rv=%b exp 0 0", pend3, rv3);
    end
  endtask

  task automatic test_violation();
    do_reset();
    bt = 1; btgt = 32'h100; exp1_q.push_back(32'h100);
    tick(); idle_inputs();
    jmp = 1; jtgt = 32'h200; tick(); idle_inputs();
    checks++;
    if (sv1 !== 1 || ra1 !== 32'h100) begin
      errors++; $display("FAIL viol_pulse: sv=%b addr=%h exp 1 00000100", sv1, ra1);
    end
    done = 1; tick(); done = 0;
    checks++;
    if (sv1 !== 0 || rv1 !== 1 || ra1 !== 32'h100) begin
      errors++; $display("FAIL viol_after: sv=%b rv=%b addr=%h exp 0 1 00000100", sv1, rv1, ra1);
    end
    bt = 1; btgt = 32'h999; tick(); idle_inputs();  // dropped while waiting for ack
    checks++;
    if (sv1 !== 1 || rv1 !== 1 || ra1 !== 32'h100) begin
      errors++; $display("FAIL viol_redirect: sv=%b rv=%b addr=%h exp 1 1 00000100", sv1, rv1, ra1);
    end
    ack = 1; tick(); ack = 0;
    checks++;
    if (pend1 !== 0 || sv1 !== 0) begin
      errors++; $display("FAIL viol_ack: pend=%b sv=%b exp 0 0", pend1, sv1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bt = 1; btgt = 32'h80; exp1_q.push_back(32'h80);
    tick(); idle_inputs();
    done = 1; tick(); done = 0;
    ack = 1; bt = 1; btgt = 32'h300; exp1_q.push_back(32'h300);
    tick(); idle_inputs();
    checks++;
    if (pend1 !== 1 || rv1 !== 0 || sl1 !== 3'd1 || sv1 !== 0 || ra1 !== 32'h300) begin
      errors++; $display("FAIL b2b_armed: pend=%b rv=%b sl=%0d sv=%b addr=%h exp 1 0 1 0 00000300", pend1, rv1, sl1, sv1, ra1);
    end
    done = 1; tick(); done = 0;
    checks++;
    if (rv1 !== 1 || ra1 !== 32'h300) begin
      errors++; $display("FAIL b2b_redirect: rv=%b addr=%h exp 1 00000300", rv1, ra1);
    end
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bt = 1; btgt = 32'h10; jmp = 1; jtgt = 32'h20; exp1_q.push_back(32'h20);
    tick(); idle_inputs();
    checks++;
    if (sv1 !== 1 || ra1 !== 32'h20 || pend1 !== 1) begin
      errors++; $display("FAIL simul_capture: sv=%b addr=%h pend=%b exp 1 00000020 1", sv1, ra1, pend1);
    end
    done = 1; tick(); done = 0;
    checks++;
    if (rv1 !== 1 || ra1 !== 32'h20 || sv1 !== 0) begin
      errors++; $display("FAIL simul_redirect: rv=%b addr=%h sv=%b exp 1 00000020 0", rv1, ra1, sv1);
    end
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_abort();
    do_reset();
    bt = 1; btgt = 32'h500; tick(); idle_inputs();
    flush = 1; done = 1; tick(); idle_inputs();
    checks++;
    if (pend1 !== 0 || sl1 !== 0 || pend3 !== 0 || sl3 !== 0 || rv1 !== 0) begin
      errors++; $display("FAIL abort_flush: pend1=%b sl1=%0d pend3=%b sl3=%0d rv1=%b exp 0", pend1, sl1, pend3, sl3, rv1);
    end
    for (int i = 0; i < 4; i++) begin done = 1; tick(); done = 0; end
    checks++;
    if (rv1 !== 0 || rv3 !== 0) begin
      errors++; $display("FAIL abort_flush_quiet: rv1=%b rv3=%b exp 0 0", rv1, rv3);
    end
    bt = 1; btgt = 32'h600; exp1_q.push_back(32'h600);
    tick(); idle_inputs();
    done = 1; tick(); done = 0;
    reset = 1; ack = 0; tick(); reset = 0;
    checks++;
    if (rv1 !== 0 || pend1 !== 0 || ra1 !== 32'h0 || pend3 !== 0 || sl3 !== 0) begin
      errors++; $display("FAIL abort_reset: rv=%b pend=%b addr=%h pend3=%b sl3=%0d exp 0 0 0 0 0", rv1, pend1, ra1, pend3, sl3);
    end
    for (int i = 0; i < 5; i++) begin done = (i % 2 == 0); tick(); done = 0; end
    checks++;
    if (rv1 !== 0 || rv3 !== 0 || pend1 !== 0) begin
      errors++; $display("FAIL abort_reset_quiet: rv1=%b rv3=%b pend1=%b exp 0 0 0", rv1, rv3, pend1);
    end
  endtask

  initial begin
    reset = 1; idle_inputs();
    test_reset();
    test_basic();
    test_multi_slots();
    test_violation();
    test_back_to_back();
    test_simultaneous();
    test_abort();
    tick(); tick();
    checks++;
    if (exp1_q.size() != 0 || exp3_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d/%0d redirects outstanding, exp 0/0", exp1_q.size(), exp3_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
